instr_fetch_rv32i: RTL and testbench

Instruction-fetch initiator for the RV32I datapath.
- Owns the PC and drives the byte address into the synchronous 32x32 instruction ROM (1-cycle read latency; word index = address[6:2]).
- Captures returned words and hands {PC, instruction} to decode over a valid/ready handshake.
- Supports backpressure and branch/jump redirect with in-flight flush, sustaining 1 instruction/cycle when decode is always ready.

---
 rtl/rv32i_pkg.sv | 25 ++
 rtl/fetch_skid_fifo.sv | 65 ++++++
 rtl/instr_fetch_rv32i.sv | 96 +++++++++
 tb/tb_instr_fetch_rv32i.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants, fetch entry type and PC helpers
package rv32i_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RV32I_NOP    = 32'h00000013;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h00000000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  // Drop the byte offset so fetch always proceeds from a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - small FIFO buffering fetched {pc, instr} entries ahead of decode
module fetch_skid_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_occ;

  logic w_do_pop;
  logic w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_pop  = pop & ~flush & (r_occ != '0);
  assign w_do_push = push & ~flush & ((r_occ != OCC_W'(DEPTH)) | w_do_pop);

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Entry storage needs no reset: empty slots are never presented.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout = r_mem[r_rd_ptr];
  assign occ  = r_occ;

endmodule

// File: rtl/instr_fetch_rv32i.sv
// rtl/instr_fetch_rv32i.sv - RV32I fetch stage: PC, ROM address issue, buffering and redirect
module instr_fetch_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_VECTOR,
  parameter logic [XLEN-1:0] NOP_INSTR = RV32I_NOP
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] ROM_ADDR,
  input  logic [XLEN-1:0] ROM_INSTR,
  input  logic            ID_READY,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IF_VALID,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_INSTR,
  output logic            MISALIGN_ERR
);

  logic [XLEN-1:0] r_pc_req;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic [XLEN-1:0] r_last_pc;
  logic            r_misalign;

  fetch_entry_t    w_din;
  fetch_entry_t    w_head;
  logic [1:0]      w_occ;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_credit;
  logic            w_issue;

  assign w_pop  = IF_VALID & ID_READY;
  assign w_push = r_inflight & ~REDIRECT;

  // Buffered plus in-flight words after this cycle's pop; issuing only below
  // two keeps the two-entry buffer from ever overflowing.
  assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue  = (w_credit < 3'd2);

  assign w_din.pc    = r_inflight_pc;
  assign w_din.instr = ROM_INSTR;

  fetch_skid_fifo #(
    .DEPTH (2)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (REDIRECT),
    .din   (w_din),
    .dout  (w_head),
    .occ   (w_occ)
  );

  // PC request, in-flight tracking and misalignment flag; redirect overrides issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc_req      <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_misalign <= REDIRECT & (REDIRECT_PC[1:0] != 2'b00);
      if (REDIRECT) begin
        r_pc_req   <= align_pc(REDIRECT_PC);
        r_inflight <= 1'b0;
      end else if (w_issue) begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc_req;
        r_pc_req      <= next_pc(r_pc_req);
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // Remember the last presented PC so IF_PC holds while nothing is valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_pc <= '0;
    end else if (IF_VALID) begin
      r_last_pc <= w_head.pc;
    end
  end

  assign ROM_ADDR     = r_pc_req;
  assign IF_VALID     = (w_occ != 2'd0);
  assign IF_PC        = IF_VALID ? w_head.pc : r_last_pc;
  assign IF_INSTR     = IF_VALID ? w_head.instr : NOP_INSTR;
  assign MISALIGN_ERR = r_misalign;

endmodule

// File: tb/tb_instr_fetch_rv32i.sv
// tb/tb_instr_fetch_rv32i.sv - self-checking bench for instr_fetch_rv32i
module tb_instr_fetch_rv32i;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ROM_ADDR;
  logic [31:0] ROM_INSTR;
  logic        ID_READY;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        MISALIGN_ERR;

  logic [31:0] rom [32];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] acc_pc [$];
  logic [31:0] acc_ins [$];
  int          base;

  logic [31:0] m_pc;
  logic [31:0] m_last;
  logic [31:0] restart_pc;
  int          since;
  logic        exp_mis;

  always #5 clock = ~clock;

  instr_fetch_rv32i dut (
    .clock        (clock),
    .reset        (reset),
    .ROM_ADDR     (ROM_ADDR),
    .ROM_INSTR    (ROM_INSTR),
    .ID_READY     (ID_READY),
    .REDIRECT     (REDIRECT),
    .REDIRECT_PC  (REDIRECT_PC),
    .IF_VALID     (IF_VALID),
    .IF_PC        (IF_PC),
    .IF_INSTR     (IF_INSTR),
    .MISALIGN_ERR (MISALIGN_ERR)
  );

  // Synchronous ROM, one cycle read latency.
  always @(posedge clock) ROM_INSTR <= rom[ROM_ADDR[6:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: the presented instruction is always the next one in
  // program order, valid appears two cycles after a restart and never drops after.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_valid", 32'(IF_VALID), 32'd0);
      chk("rst_instr", IF_INSTR, NOP);
      chk("rst_pc", IF_PC, 32'd0);
      chk("rst_rom_addr", ROM_ADDR, 32'd0);
      chk("rst_misalign", 32'(MISALIGN_ERR), 32'd0);
      m_pc = 32'd0; m_last = 32'd0; restart_pc = 32'd0; since = 0; exp_mis = 1'b0;
    end else begin
      chk("valid", 32'(IF_VALID), (since >= 2) ? 32'd1 : 32'd0);
      if (since == 0) chk("rom_addr", ROM_ADDR, restart_pc);
      chk("misalign", 32'(MISALIGN_ERR), 32'(exp_mis));
      if (IF_VALID) begin
        chk("if_pc", IF_PC, m_pc);
        chk("if_instr", IF_INSTR, rom[m_pc[6:2]]);
        m_last = m_pc;
        if (ID_READY) begin
          acc_pc.push_back(IF_PC);
          acc_ins.push_back(IF_INSTR);
          m_pc = m_pc + 32'd4;
        end
      end else begin
        chk("idle_instr", IF_INSTR, NOP);
        chk("idle_pc", IF_PC, m_last);
      end
      exp_mis = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
      if (REDIRECT) begin
        m_pc = {REDIRECT_PC[31:2], 2'b00};
        restart_pc = m_pc;
        since = 0;
      end else if (since < 100) begin
        since++;
      end
    end
  end

  task automatic wait_acc(input int need);
    int t = 0;
    while (acc_pc.size() < base + need && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    n_cmp++;
    if (acc_pc.size() < base + need) begin
      n_bad++;
      $display("FAIL wait_acc timeout actual=%0d required=%0d", acc_pc.size() - base, need);
    end
  endtask

  task automatic restart();
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    @(posedge clock); #1 REDIRECT = 1'b1; REDIRECT_PC = tgt;
    @(posedge clock); #1 REDIRECT = 1'b0;
    base = acc_pc.size();
  endtask

  // Called right after reset release; checks boot latency and first program.
  task automatic check_boot();
    logic [31:0] ep [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] ei [5] = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302023, 32'h00000013};
    base = acc_pc.size();
    @(negedge clock);
    chk("boot_valid_c0", 32'(IF_VALID), 32'd0);
    chk("boot_rom_addr", ROM_ADDR, 32'h0);
    @(negedge clock);
    chk("boot_valid_c1", 32'(IF_VALID), 32'd0);
    @(negedge clock);
    chk("boot_valid_c2", 32'(IF_VALID), 32'd1);
    wait_acc(5);
    for (int i = 0; i < 5; i++) begin
      chk("boot_pc", acc_pc[base + i], ep[i]);
      chk("boot_instr", acc_ins[base + i], ei[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = NOP;
    rom[0]  = 32'h00500093;
    rom[1]  = 32'h00700113;
    rom[2]  = 32'h002081B3;
    rom[3]  = 32'h00302023;
    rom[16] = 32'hC0DE0040;
    rom[17] = 32'hC0DE0044;
    rom[30] = 32'hC0DE0078;
    rom[31] = 32'hC0DE007C;

    reset = 1'b0; ID_READY = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("init_valid", 32'(IF_VALID), 32'd0);
    chk("init_instr", IF_INSTR, NOP);
    chk("init_rom_addr", ROM_ADDR, 32'h0);

    // Scenario 1: boot stream
    @(posedge clock); #1 reset = 1'b1;
    check_boot();

    // Scenario 2: backpressure with head 0x4
    restart();
    repeat (3) @(posedge clock);
    #1 ID_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_hold_pc", IF_PC, 32'h4);
      chk("bp_hold_instr", IF_INSTR, 32'h00700113);
      chk("bp_rom_addr", ROM_ADDR, 32'hC);
    end
    @(posedge clock); #1 ID_READY = 1'b1;
    base = acc_pc.size();
    wait_acc(3);
    chk("bp_pc0", acc_pc[base], 32'h4);
    chk("bp_pc1", acc_pc[base + 1], 32'h8);
    chk("bp_pc2", acc_pc[base + 2], 32'hC);
    chk("bp_instr2", acc_ins[base + 2], 32'h00302023);

    // Scenario 3: redirect mid-stream
    pulse_redirect(32'h40);
    @(negedge clock);
    chk("rd_valid", 32'(IF_VALID), 32'd0);
    chk("rd_rom_addr", ROM_ADDR, 32'h40);
    wait_acc(1);
    chk("rd_pc", acc_pc[base], 32'h40);
    chk("rd_instr", acc_ins[base], 32'hC0DE0040);

    // Scenario 4: misaligned redirect target
    pulse_redirect(32'h46);
    @(negedge clock);
    chk("mis_pulse", 32'(MISALIGN_ERR), 32'd1);
    chk("mis_rom_addr", ROM_ADDR, 32'h44);
    @(negedge clock);
    chk("mis_clear", 32'(MISALIGN_ERR), 32'd0);
    wait_acc(1);
    chk("mis_pc", acc_pc[base], 32'h44);
    chk("mis_instr", acc_ins[base], 32'hC0DE0044);

    // Scenario 5: PC wrap
    pulse_redirect(32'hFFFFFFF8);
    wait_acc(3);
    chk("wrap_pc0", acc_pc[base], 32'hFFFFFFF8);
    chk("wrap_pc1", acc_pc[base + 1], 32'hFFFFFFFC);
    chk("wrap_pc2", acc_pc[base + 2], 32'h00000000);
    chk("wrap_in0", acc_ins[base], 32'hC0DE0078);
    chk("wrap_in1", acc_ins[base + 1], 32'hC0DE007C);
    chk("wrap_in2", acc_ins[base + 2], 32'h00500093);

    // Back-to-back redirects: last one wins
    @(posedge clock); #1 REDIRECT = 1'b1; REDIRECT_PC = 32'h20;
    @(posedge clock); #1 REDIRECT_PC = 32'h60;
    @(posedge clock); #1 REDIRECT = 1'b0;
    base = acc_pc.size();
    wait_acc(1);
    chk("b2b_pc", acc_pc[base], 32'h60);

    // Scenario 6: async reset with two buffered entries
    ID_READY = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(IF_VALID), 32'd0);
    chk("ar_instr", IF_INSTR, NOP);
    chk("ar_rom_addr", ROM_ADDR, 32'h0);
    chk("ar_pc", IF_PC, 32'h0);
    @(posedge clock); #1 ID_READY = 1'b1; reset = 1'b1;
    check_boot();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
